zapper_sensor: RTL and testbench
================================

// Module: zapper_sensor
// PURPOSE
// Light-gun (Zapper) model. It watches the PPU pixel stream (colour index plus dot and line counters)
// next to the video stage and decides whether the aimed spot is lit. It produces the light-sense and
// trigger bits for the controller port, and the reticule flag that the video stage overlays as a crosshair.
// PARAMETERS
// BRIGHT_ROW   2   min colour row (color[5:4]) counted as bright; row 3 is always bright
// RADIUS       2   half-size of the square sensing window, in dots/lines
// HIT_MIN      3   bright dots per frame inside the window needed to sense light
// HOLD_LINES   26  scanlines that light stays asserted after the last hit
// RET_LEN      3   crosshair arm half-length, in dots/lines
// DEB_CYCLES   1024  clk cycles trigger_in must stay stable before it is accepted
// TRIG_FRAMES  3   frames that trigger stays high after an accepted press
// PORTS
// clk          in   1  system clock
// reset_n      in   1  asynchronous active-low reset
// ce           in   1  one-clk strobe, once per PPU dot
// color        in   6  PPU colour index of the current dot
// count_h      in   9  PPU dot counter, 0..340
// count_v      in   9  PPU line counter, 0..260, with 511 as the pre-render line
// gun_x        in   8  aim X, in visible dots
// gun_y        in   8  aim Y, in visible lines
// gun_off      in   1  aim is off-screen; never sense light
// trigger_in   in   1  raw asynchronous trigger button
// ret_en       in   1  enable crosshair overlay
// light        out  1  light sensed, active high (the port logic inverts it)
// trigger      out  1  stretched trigger
// reticule     out  1  current dot is on the crosshair
// BEHAVIOUR
// - Reset: light=0, trigger=0, reticule=0. All counters and latches clear; the debounced level is 0.
// - Frame start: on a ce where the previous count_v was 511 and count_v is 0.
//   At frame start, latch gun_x, gun_y and gun_off into ax, ay, aoff, and clear hit_cnt.
// - bright = (color[3:0] <= 4'hC) && (color[5:4] >= BRIGHT_ROW).
// - in_win = |count_h - ax| <= RADIUS && |count_v - ay| <= RADIUS && count_h < 256 && count_v < 240.
//   Differences are computed at 10-bit signed width; there is no wrap at the screen edges.
// - On each ce with in_win && bright && !aoff: hit_cnt increments, saturating at HIT_MIN.
//   When it reaches HIT_MIN, hold is loaded with HOLD_LINES.
// - Line end (ce && count_h == 340): hold decrements if nonzero.
//   If a reload and a decrement happen on the same ce, the reload wins.
// - light = (hold != 0), registered. aoff == 1 forces hold to 0 on the next ce.
// - Reticule: registered every clk, so latency is 1 clk from the counters.
//   reticule = ret_en && !aoff && count_h < 256 && count_v < 240 &&
//   ((count_h == ax && |count_v - ay| <= RET_LEN) || (count_v == ay && |count_h - ax| <= RET_LEN)).
// - Trigger path:
//   - trigger_in passes through a 2-flop synchroniser, then a debouncer.
//   - The debouncer updates its output level only after DEB_CYCLES consecutive equal samples.
//   - A rising edge of the debounced level sets trigger=1 and loads tfr with TRIG_FRAMES.
//   - Each frame start decrements tfr; when tfr reaches 0, trigger=0.
//   - A new edge while trigger=1 reloads tfr.
// - Asserting reset_n low mid-frame clears all state immediately. Sensing restarts only after the next frame start.
// - A gun position change mid-frame has no effect until the next frame start.
// STRUCTURE
// - Package zapper_pkg holds: H_LAST = 340, VIS_W = 256, VIS_H = 240, PRE_V = 511, and the function is_bright().
// - Sub-module zapper_debounce (synchroniser + stable counter, parameter DEB_CYCLES).
// - Everything else lives in zapper_sensor.
// TESTING
// 1. Aim (100,100); colour 0x30 on dots 99..101 of line 100 ->
//    light rises on the 3rd hit, stays high 26 line ends, then falls.
// 2. Same frame with colour 0x0F in the window -> light stays 0; hit_cnt stays 0.
// 3. Crosshair at aim (10,20) with ret_en=1 -> reticule high at (10,17..23) and (7..13,20), low elsewhere.
//    With ret_en=0 it stays low throughout.
// 4. Trigger_in pulses 500 clk (bounce) -> no trigger.
//    A 2000 clk press -> trigger high for exactly 3 frame starts.
// 5. Edge and offscreen cases:
//    - Aim (0,0) with bright at dot 0 -> light, and no false hits at dots 254..255.
//    - gun_off=1 with a full-white frame -> light stays 0.
// 6. Pull reset_n low mid-hold -> light, trigger and reticule go to 0 asynchronously.
//    Next hit is sensed only after the following frame start.

Source files
------------

// File: rtl/zapper_pkg.sv
// Shared constants and helpers for the Zapper light-gun model.
package zapper_pkg;

  localparam int unsigned CNT_W  = 9;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned POS_W  = 8;
  localparam int unsigned H_LAST = 340;
  localparam int unsigned VIS_W  = 256;
  localparam int unsigned VIS_H  = 240;
  localparam int unsigned PRE_V  = 511;

  // Grey/black columns 0xD..0xF never count; rows below min_row are too dark.
  function automatic logic is_bright(input logic [COL_W-1:0] color,
                                     input logic [1:0]       min_row);
    return (color[3:0] <= 4'hC) && (color[5:4] >= min_row);
  endfunction

  // |a - b| <= r at 10-bit signed width, with no wrap at the screen edges.
  function automatic logic near(input logic [CNT_W-1:0] a,
                                input logic [CNT_W-1:0] b,
                                input int unsigned      r);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d <= $signed(10'(r))) && (d >= -$signed(10'(r)));
  endfunction

endpackage

// File: rtl/zapper_debounce.sv
// Trigger button synchroniser followed by a stable-sample debouncer.
module zapper_debounce #(
  parameter int unsigned DEB_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic trig_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= trig_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/zapper_sensor.sv
// Zapper light-gun model: windowed light sensing, crosshair overlay and a
// debounced, frame-stretched trigger.
module zapper_sensor
  import zapper_pkg::*;
#(
  parameter int unsigned BRIGHT_ROW  = 2,
  parameter int unsigned RADIUS      = 2,
  parameter int unsigned HIT_MIN     = 3,
  parameter int unsigned HOLD_LINES  = 26,
  parameter int unsigned RET_LEN     = 3,
  parameter int unsigned DEB_CYCLES  = 1024,
  parameter int unsigned TRIG_FRAMES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [COL_W-1:0] color,
  input  logic [CNT_W-1:0] count_h,
  input  logic [CNT_W-1:0] count_v,
  input  logic [POS_W-1:0] gun_x,
  input  logic [POS_W-1:0] gun_y,
  input  logic             gun_off,
  input  logic             trigger_in,
  input  logic             ret_en,
  output logic             light,
  output logic             trigger,
  output logic             reticule
);

  localparam int unsigned HCW = $clog2(HIT_MIN + 1);
  localparam int unsigned HLW = $clog2(HOLD_LINES + 1);
  localparam int unsigned TFW = $clog2(TRIG_FRAMES + 1);

  logic [CNT_W-1:0] prev_v_q, prev_v_d;
  logic [POS_W-1:0] ax_q, ax_d, ay_q, ay_d;
  logic             aoff_q, aoff_d;
  logic             armed_q, armed_d;
  logic [HCW-1:0]   hit_cnt_q, hit_cnt_d;
  logic [HLW-1:0]   hold_q, hold_d;
  logic             light_q, light_d;
  logic             ret_q, ret_d;
  logic [TFW-1:0]   tfr_q, tfr_d;
  logic             trig_q, trig_d;
  logic             deb_level, deb_prev_q;

  logic             frame_start;
  logic [POS_W-1:0] ax_e, ay_e;
  logic             aoff_e, armed_e;
  logic [HCW-1:0]   hit_base;
  logic             in_win, hit, reload, line_end, trig_edge;

  zapper_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .trig_i  (trigger_in),
    .level_o (deb_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_v_q   <= '0;
      ax_q       <= '0;
      ay_q       <= '0;
      aoff_q     <= 1'b0;
      armed_q    <= 1'b0;
      hit_cnt_q  <= '0;
      hold_q     <= '0;
      light_q    <= 1'b0;
      ret_q      <= 1'b0;
      tfr_q      <= '0;
      trig_q     <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      prev_v_q   <= prev_v_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      aoff_q     <= aoff_d;
      armed_q    <= armed_d;
      hit_cnt_q  <= hit_cnt_d;
      hold_q     <= hold_d;
      light_q    <= light_d;
      ret_q      <= ret_d;
      tfr_q      <= tfr_d;
      trig_q     <= trig_d;
      deb_prev_q <= deb_level;
    end
  end

  // On the frame-start dot the freshly latched aim already applies.
  always_comb begin
    frame_start = ce && (prev_v_q == CNT_W'(PRE_V)) && (count_v == '0);
    ax_e        = frame_start ? gun_x   : ax_q;
    ay_e        = frame_start ? gun_y   : ay_q;
    aoff_e      = frame_start ? gun_off : aoff_q;
    armed_e     = armed_q || frame_start;
    hit_base    = frame_start ? '0 : hit_cnt_q;
    line_end    = (count_h == CNT_W'(H_LAST));
    in_win      = near(count_h, {1'b0, ax_e}, RADIUS) &&
                  near(count_v, {1'b0, ay_e}, RADIUS) &&
                  (count_h < CNT_W'(VIS_W)) && (count_v < CNT_W'(VIS_H));
    hit         = armed_e && !aoff_e && in_win && is_bright(color, 2'(BRIGHT_ROW));
  end

  // Per-dot sensing state: aim latches, hit counter and scanline hold.
  always_comb begin
    prev_v_d  = prev_v_q;
    ax_d      = ax_q;
    ay_d      = ay_q;
    aoff_d    = aoff_q;
    armed_d   = armed_q;
    hit_cnt_d = hit_cnt_q;
    hold_d    = hold_q;
    reload    = 1'b0;
    if (ce) begin
      prev_v_d  = count_v;
      ax_d      = ax_e;
      ay_d      = ay_e;
      aoff_d    = aoff_e;
      armed_d   = armed_e;
      hit_cnt_d = hit_base;
      if (hit && (hit_base < HCW'(HIT_MIN))) begin
        hit_cnt_d = hit_base + HCW'(1);
        reload    = (hit_cnt_d == HCW'(HIT_MIN));
      end
      if (aoff_e) begin
        hold_d = '0;
      end else if (reload) begin
        hold_d = HLW'(HOLD_LINES);
      end else if (line_end && (hold_q != '0)) begin
        hold_d = hold_q - HLW'(1);
      end
    end
    light_d = (hold_d != '0);
  end

  // Crosshair evaluated every clk from the live counters and latched aim.
  always_comb begin
    ret_d = ret_en && !aoff_q &&
            (count_h < CNT_W'(VIS_W)) && (count_v < CNT_W'(VIS_H)) &&
            (((count_h == {1'b0, ax_q}) && near(count_v, {1'b0, ay_q}, RET_LEN)) ||
             ((count_v == {1'b0, ay_q}) && near(count_h, {1'b0, ax_q}, RET_LEN)));
  end

  // A new debounced press reloads the frame stretch even while already high.
  always_comb begin
    trig_edge = deb_level && !deb_prev_q;
    tfr_d     = tfr_q;
    if (trig_edge) begin
      tfr_d = TFW'(TRIG_FRAMES);
    end else if (frame_start && (tfr_q != '0)) begin
      tfr_d = tfr_q - TFW'(1);
    end
    trig_d = (tfr_d != '0);
  end

  assign light    = light_q;
  assign trigger  = trig_q;
  assign reticule = ret_q;

endmodule

// File: tb/tb_zapper_sensor.sv
// Self-checking bench for zapper_sensor: directed scenarios plus randomized
// frames compared against a behavioural model of the sensing rules.
module tb_zapper_sensor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic [5:0] color;
  logic [8:0] count_h, count_v;
  logic [7:0] gun_x, gun_y;
  logic       gun_off, trigger_in, ret_en;
  logic       light, trigger, reticule;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_ax, m_ay, m_prev_v, m_hits, m_hold;
  bit m_aoff, m_armed;

  zapper_sensor dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .color      (color),
    .count_h    (count_h),
    .count_v    (count_v),
    .gun_x      (gun_x),
    .gun_y      (gun_y),
    .gun_off    (gun_off),
    .trigger_in (trigger_in),
    .ret_en     (ret_en),
    .light      (light),
    .trigger    (trigger),
    .reticule   (reticule)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic bit m_bright(input int c);
    return ((c % 16) <= 12) && ((c / 16) >= 2);
  endfunction

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_prev_v = 0; m_hits = 0; m_hold = 0;
    m_aoff = 0; m_armed = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One PPU dot: drive, advance the model, then compare light and reticule.
  task automatic dot(input int h, input int v, input int c);
    bit exp_ret, in_win, reached;
    count_h = 9'(h);
    count_v = 9'(v);
    color   = 6'(c);
    ce      = 1'b1;
    exp_ret = ret_en && !m_aoff && h < 256 && v < 240 &&
              ((h == m_ax && iabs(v - m_ay) <= 3) ||
               (v == m_ay && iabs(h - m_ax) <= 3));
    if (m_prev_v == 511 && v == 0) begin
      m_ax = int'(gun_x); m_ay = int'(gun_y); m_aoff = gun_off;
      m_hits = 0; m_armed = 1;
    end
    m_prev_v = v;
    in_win = iabs(h - m_ax) <= 2 && iabs(v - m_ay) <= 2 && h < 256 && v < 240;
    reached = 0;
    if (m_armed && !m_aoff && in_win && m_bright(c) && m_hits < 3) begin
      m_hits++;
      reached = (m_hits == 3);
    end
    if (m_aoff)           m_hold = 0;
    else if (reached)     m_hold = 26;
    else if (h == 340 && m_hold > 0) m_hold--;
    @(posedge clk);
    #1;
    ce = 1'b0;
    check($sformatf("light@(%0d,%0d)", h, v), light, m_hold != 0);
    check($sformatf("reticule@(%0d,%0d)", h, v), reticule, exp_ret);
  endtask

  task automatic frame();
    dot(340, 511, 'h0F);
    dot(0, 0, 'h0F);
  endtask

  initial begin
    reset_n = 1'b0; ce = 1'b0; color = '0; count_h = '0; count_v = '0;
    gun_x = '0; gun_y = '0; gun_off = 1'b0; trigger_in = 1'b0; ret_en = 1'b0;
    model_reset();
    #1;
    check("reset_light", light, 1'b0);
    check("reset_trigger", trigger, 1'b0);
    check("reset_reticule", reticule, 1'b0);
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Three bright dots light the sensor; hold lasts 26 line ends.
    gun_x = 8'd100; gun_y = 8'd100;
    frame();
    dot(99, 100, 'h30);
    check("t1_two_hits_dark", light, 1'b0);
    dot(100, 100, 'h30);
    check("t1_two_hits_dark2", light, 1'b0);
    dot(101, 100, 'h30);
    check("t1_third_hit_lit", light, 1'b1);
    for (int i = 0; i < 26; i++) begin
      dot(340, 100 + i, 'h0F);
      check($sformatf("t1_hold_%0d", i), light, i < 25);
    end

    // Dark colours inside the window never count.
    frame();
    for (int v = 98; v <= 102; v++)
      for (int h = 98; h <= 102; h++) dot(h, v, 'h0F);
    check("t2_dark_window", light, 1'b0);
    dot(100, 101, 'h1C);
    dot(101, 101, 'h2D);
    check("t2_row_and_column_limits", light, 1'b0);

    // Crosshair sweep with and without the overlay enable.
    gun_x = 8'd10; gun_y = 8'd20; ret_en = 1'b1;
    frame();
    for (int v = 16; v <= 24; v++)
      for (int h = 6; h <= 14; h++) dot(h, v, 'h0F);
    dot(10, 17, 'h0F);
    check("t3_ret_top_arm", reticule, 1'b1);
    dot(14, 20, 'h0F);
    check("t3_ret_past_arm", reticule, 1'b0);
    ret_en = 1'b0;
    for (int v = 16; v <= 24; v++)
      for (int h = 6; h <= 14; h++) dot(h, v, 'h0F);

    // Bouncy trigger is rejected; a long press stretches over 3 frame starts.
    for (int i = 0; i < 3; i++) begin
      trigger_in = 1'b1; idle(500);
      trigger_in = 1'b0; idle(500);
    end
    check("t4_bounce_rejected", trigger, 1'b0);
    trigger_in = 1'b1; idle(600);
    check("t4_press_pending", trigger, 1'b0);
    idle(1400);
    check("t4_press_accepted", trigger, 1'b1);
    trigger_in = 1'b0; idle(1200);
    check("t4_held_after_release", trigger, 1'b1);
    frame();
    check("t4_after_fs1", trigger, 1'b1);
    frame();
    check("t4_after_fs2", trigger, 1'b1);
    frame();
    check("t4_after_fs3", trigger, 1'b0);

    // Screen-edge aim: no wrap-around hits, then real hits at dot 0.
    gun_x = 8'd0; gun_y = 8'd0;
    frame();
    dot(254, 0, 'h30); dot(255, 0, 'h30); dot(254, 1, 'h30);
    dot(255, 1, 'h30); dot(255, 2, 'h30);
    check("t5_no_wrap_hits", light, 1'b0);
    dot(0, 1, 'h30); dot(1, 1, 'h30); dot(0, 2, 'h30);
    check("t5_edge_lit", light, 1'b1);
    gun_x = 8'd50; gun_y = 8'd50; gun_off = 1'b1;
    frame();
    check("t5_off_clears_hold", light, 1'b0);
    for (int v = 48; v <= 52; v++)
      for (int h = 48; h <= 52; h++) dot(h, v, 'h30);
    check("t5_off_white_frame", light, 1'b0);
    gun_off = 1'b0;

    // Asynchronous reset mid-hold, then sensing waits for a frame start.
    gun_x = 8'd100; gun_y = 8'd100; ret_en = 1'b1;
    trigger_in = 1'b1; idle(1100);
    trigger_in = 1'b0;
    frame();
    dot(99, 100, 'h30); dot(100, 99, 'h30); dot(101, 101, 'h30);
    dot(340, 101, 'h0F);
    dot(100, 100, 'h0F);
    check("t6_pre_light", light, 1'b1);
    check("t6_pre_trigger", trigger, 1'b1);
    check("t6_pre_reticule", reticule, 1'b1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_light", light, 1'b0);
    check("t6_async_trigger", trigger, 1'b0);
    check("t6_async_reticule", reticule, 1'b0);
    idle(3);
    reset_n = 1'b1;
    idle(1);
    dot(0, 1, 'h30); dot(1, 1, 'h30); dot(0, 2, 'h30);
    dot(99, 100, 'h30); dot(100, 100, 'h30); dot(101, 100, 'h30);
    check("t6_not_armed", light, 1'b0);
    frame();
    dot(99, 100, 'h30); dot(100, 100, 'h30); dot(101, 100, 'h30);
    check("t6_rearmed", light, 1'b1);

    // Randomized frames against the model.
    for (int f = 0; f < 8; f++) begin
      int ax, ay;
      ax = int'($urandom_range(0, 255));
      ay = int'($urandom_range(0, 239));
      gun_x = 8'(ax); gun_y = 8'(ay);
      gun_off = ($urandom_range(0, 5) == 0);
      ret_en = 1'($urandom_range(0, 1));
      frame();
      for (int v = ay - 3; v <= ay + 3; v++) begin
        if (v < 0 || v > 260) continue;
        for (int h = ax - 4; h <= ax + 4; h++) begin
          if (h < 0 || h > 339) continue;
          dot(h, v, int'($urandom_range(0, 63)));
        end
        dot(340, v, int'($urandom_range(0, 63)));
      end
    end
    gun_off = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
